// File: rtl/alu_defs_pkg.sv
// Shared ALU control codes, legality check and default request record for
// the MIPSALU issue front end.
package alu_defs_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 4;

    // Default-width request record; the issue unit re-declares it with its own widths.
    typedef struct packed {
        logic [3:0]           ctl;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic [DEF_TAG_W-1:0] tag;
    } alu_req_t;

    function automatic logic is_legal_ctl(input logic [3:0] ctl);
        logic legal;
        legal = 1'b0;
        case (ctl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO for the ALU issuer; element type is a parameter so
// the top can store a request record sized to its own operand/tag widths.
module alu_req_fifo
    import alu_defs_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = alu_req_t,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  T               push_data,
    input  logic           pop,
    output T               head,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    T mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset: head is only consumed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Requester-side front end for the combinational MIPSALU: queues requests,
// presents the head to the ALU and registers the result on a valid/ready port.
module alu_issue_unit
    import alu_defs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_ctl,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]       ctl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t             req_in;
    req_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_count;
    logic             push;
    logic             capture;
    logic             head_legal;

    assign req_in = '{ctl: req_ctl, a: req_a, b: req_b, tag: req_tag};

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign capture   = !fifo_empty && (!res_valid || res_ready);

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (req_in),
        .pop       (capture),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ALU inputs are held at zero while idle so the datapath sees no stale operands.
    always_comb begin
        alu_ctl = '0;
        alu_a   = '0;
        alu_b   = '0;
        if (!fifo_empty) begin
            alu_ctl = head.ctl;
            alu_a   = head.a;
            alu_b   = head.b;
        end
    end

    assign head_legal = is_legal_ctl(head.ctl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_tag   <= head.tag;
            if (head_legal) begin
                res_data <= alu_out;
                res_zero <= alu_zero;
                res_err  <= 1'b0;
            end else begin
                res_data <= '0;
                res_zero <= 1'b1;
                res_err  <= 1'b1;
            end
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign busy = (fifo_count != '0) || res_valid;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural MIPSALU attached to
// the alu_* port; expected results are hand-computed constants.
module tb_alu_issue_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_ctl;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctl   (req_ctl),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .alu_ctl   (alu_ctl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_tag   (res_tag),
        .res_err   (res_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unsupported codes return a nonzero junk value so error masking is observable.
    always_comb begin
        case (alu_ctl)
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd7:    alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'd12:   alu_out = ~(alu_a | alu_b);
            default: alu_out = (alu_a ^ alu_b) | 32'h8000_0000;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic [3:0] c, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        req_valid = v;
        req_ctl   = c;
        req_a     = a;
        req_b     = b;
        req_tag   = t;
    endtask

    typedef struct {
        logic [3:0]       ctl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] exp_data;
        logic             exp_zero;
        logic             exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [TAG_W-1:0] exp_q [$];
        logic [TAG_W-1:0] next_tag;
        int pushed;
        int guard;
        int mcount;
        logic mrv;
        logic will_push;
        logic will_cap;

        vecs[0] = '{4'd6,  32'hD,         32'h6, 4'd1,  32'h7,         1'b0, 1'b0};
        vecs[1] = '{4'd0,  32'hC,         32'hA, 4'd2,  32'h8,         1'b0, 1'b0};
        vecs[2] = '{4'd1,  32'h5,         32'hA, 4'd3,  32'hF,         1'b0, 1'b0};
        vecs[3] = '{4'd2,  32'hFFFF_FFFF, 32'h1, 4'd4,  32'h0,         1'b1, 1'b0};
        vecs[4] = '{4'd7,  32'h3,         32'h5, 4'd5,  32'h1,         1'b0, 1'b0};
        vecs[5] = '{4'd7,  32'h5,         32'h3, 4'd6,  32'h0,         1'b1, 1'b0};
        vecs[6] = '{4'd12, 32'h0,         32'h0, 4'd7,  32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{4'd4,  32'h3,         32'h1, 4'd8,  32'h0,         1'b1, 1'b1};
        vecs[8] = '{4'd6,  32'h5,         32'h5, 4'd9,  32'h0,         1'b1, 1'b0};
        vecs[9] = '{4'd15, 32'h9,         32'h2, 4'd10, 32'h0,         1'b1, 1'b1};

        rst_n     = 1'b0;
        res_ready = 1'b1;
        drive_req(1'b0, 4'd0, '0, '0, '0);
        #12;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_alu_a",     64'(alu_a),     64'd0);
        check("rst_res_data",  64'(res_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // One request at a time: issue view after the push edge, result after the next.
        for (int i = 0; i < 10; i++) begin
            drive_req(1'b1, vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].tag);
            @(negedge clk);
            drive_req(1'b0, 4'd0, '0, '0, '0);
            check($sformatf("v%0d_alu_ctl", i), 64'(alu_ctl), 64'(vecs[i].ctl));
            check($sformatf("v%0d_alu_a", i),   64'(alu_a),   64'(vecs[i].a));
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 64'(res_valid), 64'd1);
            check($sformatf("v%0d_data", i),  64'(res_data),  64'(vecs[i].exp_data));
            check($sformatf("v%0d_zero", i),  64'(res_zero),  64'(vecs[i].exp_zero));
            check($sformatf("v%0d_tag", i),   64'(res_tag),   64'(vecs[i].tag));
            check($sformatf("v%0d_err", i),   64'(res_err),   64'(vecs[i].exp_err));
        end
        @(negedge clk);
        check("idle_valid", 64'(res_valid), 64'd0);
        check("idle_busy",  64'(busy),      64'd0);
        check("idle_alu_ctl", 64'(alu_ctl), 64'd0);

        // Back-to-back SUBs, one result per cycle in order.
        drive_req(1'b1, 4'd6, 32'hF, 32'h2, 4'd2);
        @(negedge clk);
        drive_req(1'b1, 4'd6, 32'h5, 32'h5, 4'd3);
        @(negedge clk);
        drive_req(1'b0, 4'd0, '0, '0, '0);
        check("b2b0_tag",  64'(res_tag),  64'd2);
        check("b2b0_data", 64'(res_data), 64'hD);
        check("b2b0_zero", 64'(res_zero), 64'd0);
        @(negedge clk);
        check("b2b1_valid", 64'(res_valid), 64'd1);
        check("b2b1_tag",   64'(res_tag),   64'd3);
        check("b2b1_data",  64'(res_data),  64'h0);
        check("b2b1_zero",  64'(res_zero),  64'd1);
        @(negedge clk);
        check("b2b_drained", 64'(res_valid), 64'd0);

        // Backpressure: five ADDs, one in the result slot and four filling the FIFO.
        res_ready = 1'b0;
        pushed = 0;
        guard  = 0;
        while (pushed < 5 && guard < 20) begin
            drive_req(1'b1, 4'd2, 32'(3 * (pushed + 4)), 32'h1, 4'(pushed + 4));
            #1;
            if (req_ready) pushed++;
            @(negedge clk);
            guard++;
        end
        drive_req(1'b0, 4'd0, '0, '0, '0);
        check("bp_pushed", 64'(pushed), 64'd5);
        check("bp_full_ready", 64'(req_ready), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        res_ready = 1'b1;
        for (int t = 4; t < 9; t++) begin
            check($sformatf("bp_valid_t%0d", t), 64'(res_valid), 64'd1);
            check($sformatf("bp_tag_t%0d", t),   64'(res_tag),   64'(t));
            check($sformatf("bp_data_t%0d", t),  64'(res_data),  64'(3 * t + 1));
            @(negedge clk);
        end
        check("bp_end_valid", 64'(res_valid), 64'd0);
        check("bp_end_busy",  64'(busy),      64'd0);

        // Sustained push with consumer stalled, then released while full.
        res_ready = 1'b0;
        next_tag  = 4'd0;
        mcount    = 0;
        mrv       = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            res_ready = (cyc >= 6);
            drive_req(1'b1, 4'd2, 32'(next_tag), 32'h100, next_tag);
            #1;
            check($sformatf("sp_ready_c%0d", cyc), 64'(req_ready), 64'(mcount < DEPTH));
            will_push = req_valid && (mcount < DEPTH);
            will_cap  = (mcount > 0) && (!mrv || res_ready);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("sp_unexpected_result", 64'(res_tag), 64'hFF);
                end else begin
                    check($sformatf("sp_tag_c%0d", cyc), 64'(res_tag), 64'(exp_q[0]));
                    check($sformatf("sp_data_c%0d", cyc), 64'(res_data), 64'(exp_q[0]) + 64'h100);
                    void'(exp_q.pop_front());
                end
            end
            if (req_ready) begin
                exp_q.push_back(next_tag);
                next_tag = next_tag + 1'b1;
            end
            mcount = mcount + int'(will_push) - int'(will_cap);
            if (will_cap) mrv = 1'b1;
            else if (mrv && res_ready) mrv = 1'b0;
            @(negedge clk);
        end
        drive_req(1'b0, 4'd0, '0, '0, '0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            #1;
            if (res_valid) begin
                check("sp_drain_tag", 64'(res_tag), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            @(negedge clk);
            guard++;
        end
        check("sp_left_over", 64'(exp_q.size()), 64'd0);
        check("sp_idle_busy", 64'(busy), 64'd0);

        // Asynchronous reset with three requests queued behind a stalled result.
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_req(1'b1, 4'd2, 32'(k), 32'h1, 4'(11 + k));
            @(negedge clk);
        end
        drive_req(1'b0, 4'd0, '0, '0, '0);
        check("mr_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 64'(res_valid), 64'd0);
        check("mr_busy",  64'(busy),      64'd0);
        check("mr_alu_a", 64'(alu_a),     64'd0);
        check("mr_alu_b", 64'(alu_b),     64'd0);
        check("mr_alu_ctl", 64'(alu_ctl), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mr_no_stale_%0d", k), 64'(res_valid), 64'd0);
        end
        drive_req(1'b1, 4'd0, 32'hC, 32'hA, 4'd14);
        @(negedge clk);
        drive_req(1'b0, 4'd0, '0, '0, '0);
        @(negedge clk);
        check("mr_post_tag",  64'(res_tag),  64'd14);
        check("mr_post_data", 64'(res_data), 64'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Requester-side front end for the combinational MIPSALU: buffers operation requests (ALUctl, A, B, tag) in a small FIFO and drives them one at a time onto the ALU inputs.
- Registers ALUOut/Zero with the tag and returns them over a valid/ready result channel.
- Replaces testbench-style stimulus with a synthesizable issuer so datapath and verification code can stream ALU operations with backpressure.

Parameters:
- WIDTH, 32, operand/result width
- DEPTH, 4, request FIFO entries (power of 2, >=2)
- TAG_W, 4, request tag width, passed through unchanged

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request FIFO can accept
- req_ctl  in  4  ALU control code
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_tag  in  TAG_W  request tag
- alu_ctl  out  4  to MIPSALU ALUctl
- alu_a  out  WIDTH  to MIPSALU A
- alu_b  out  WIDTH  to MIPSALU B
- alu_out  in  WIDTH  from MIPSALU ALUOut (combinational)
- alu_zero  in  1  from MIPSALU Zero
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer takes result
- res_data  out  WIDTH  captured ALUOut
- res_zero  out  1  captured Zero
- res_tag  out  TAG_W  tag of the result
- res_err  out  1  request had an unsupported ctl code
- busy  out  1  FIFO non-empty or res_valid

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empties (rd/wr pointers and count = 0).
  - res_valid=0; res_data=0, res_zero=0, res_tag=0, res_err=0.
  - alu_ctl=0, alu_a=0, alu_b=0; busy=0; req_ready=1 after release.
  - Reset mid-operation discards all queued and pending results; nothing is replayed.
- Accept: req_ready = (count < DEPTH). A push occurs on a rising edge with req_valid && req_ready.
- Issue: alu_ctl/alu_a/alu_b combinationally present the FIFO head when non-empty, and all zeros when empty.
- Capture fires on an edge when FIFO non-empty && (!res_valid || res_ready):
  - pop head; res_data<=alu_out; res_zero<=alu_zero; res_tag<=head tag; res_valid<=1.
- Unsupported ctl:
  - Legal codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
  - Any other code is still driven to the ALU but captured with res_data=0, res_zero=1, res_err=1.
- Drain: an edge with res_valid && res_ready and no capture clears res_valid; data fields hold their last value.
- Latency: a request accepted on edge N (empty FIFO, free result slot) gives res_valid=1 after edge N+1. Throughput is 1 result/cycle while res_ready=1.
- Simultaneous push and pop in one edge: count unchanged; valid whenever count<DEPTH before the edge. When full, req_ready=0, so no push occurs even if a pop happens that edge.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Ordering is strict FIFO; results leave in request order.
- No arithmetic is done locally; the width of every captured field equals its port width.

Decomposition:
- Shared package alu_defs_pkg:
  - ALU control code constants (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12).
  - An is_legal_ctl function.
  - The request struct {ctl, a, b, tag}.
- One sub-module: alu_req_fifo (parameterized synchronous FIFO, DEPTH x request struct, push/pop/full/empty/count). The issue/capture logic stays in alu_issue_unit.

Test Plan:
- Single SUB: ctl=6, A=0xD, B=0x6, tag=1, res_ready=1 -> next cycle res_valid=1, res_data=0x7, res_zero=0, res_tag=1, res_err=0.
- Back-to-back: SUB 0xF-0x2 (tag 2) then SUB 0x5-0x5 (tag 3) on consecutive cycles -> results 0xD/zero=0, then 0x0/zero=1, in order, one per cycle.
- Backpressure: res_ready=0, push 5 ADDs -> first captured, 4 fill the FIFO, req_ready=0 when full. Release res_ready -> 5 results in tag order, busy falls after the last.
- Illegal ctl=4, A=0x3, B=0x1 -> res_err=1, res_data=0, res_zero=1. A following AND 0xC&0xA -> 0x8, res_err=0.
- Simultaneous push/pop at full (res_ready=1, req_valid held) -> count stays at DEPTH-1/DEPTH boundary, no lost or duplicated tags.
- Reset mid-stream: 3 requests queued, rst_n=0 asynchronously between edges -> res_valid=0, busy=0, alu_* = 0 immediately. No stale results after release.
